// File: rtl/change_dispenser_pkg.sv
// Shared constants for the change dispenser: state encoding, denominations,
// one-hot select codes and fault codes.
package change_dispenser_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SELECT = 5'b00010,
    ST_REQ    = 5'b00100,
    ST_DONE   = 5'b01000,
    ST_FAULT  = 5'b10000
  } state_t;

  localparam int unsigned NUM_DEN = 5;

  localparam logic [7:0] DEN_50 = 8'd50;
  localparam logic [7:0] DEN_20 = 8'd20;
  localparam logic [7:0] DEN_10 = 8'd10;
  localparam logic [7:0] DEN_5  = 8'd5;
  localparam logic [7:0] DEN_1  = 8'd1;

  localparam logic [4:0] SEL_50 = 5'b10000;
  localparam logic [4:0] SEL_20 = 5'b01000;
  localparam logic [4:0] SEL_10 = 5'b00100;
  localparam logic [4:0] SEL_5  = 5'b00010;
  localparam logic [4:0] SEL_1  = 5'b00001;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_SHORTFALL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT   = 2'b10;

  function automatic logic [7:0] sel_value(input logic [4:0] sel);
    case (sel)
      SEL_50:  return DEN_50;
      SEL_20:  return DEN_20;
      SEL_10:  return DEN_10;
      SEL_5:   return DEN_5;
      SEL_1:   return DEN_1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_stock_bank.sv
// Per-denomination stock counters: bulk reload plus one decrement port
// addressed by the one-hot dispense select (bit 4 = 50 ... bit 0 = 1).
module coin_stock_bank
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0] STOCK_INIT = 8'd20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       reload,
  input  logic       dec,
  input  logic [4:0] dec_sel,
  output logic [7:0] stock_50,
  output logic [7:0] stock_20,
  output logic [7:0] stock_10,
  output logic [7:0] stock_5,
  output logic [7:0] stock_1,
  output logic [4:0] nonzero
);

  for (genvar g = 0; g < NUM_DEN; g++) begin : g_cnt
    logic [7:0] cnt;

    always_ff @(posedge sys_clk) begin
      if (sys_rst || reload) begin
        cnt <= STOCK_INIT;
      end else if (dec && dec_sel[g] && (cnt != '0)) begin
        cnt <= cnt - 8'd1;
      end
    end

    assign nonzero[g] = (cnt != '0);
  end

  assign stock_1  = g_cnt[0].cnt;
  assign stock_5  = g_cnt[1].cnt;
  assign stock_10 = g_cnt[2].cnt;
  assign stock_20 = g_cnt[3].cnt;
  assign stock_50 = g_cnt[4].cnt;

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount greedily as 50/20/10/5/1 units, one req/ack
// handshake per unit, with shortfall and mechanism-timeout faults.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0]  STOCK_INIT  = 8'd20,
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned TO_W        = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic       restock,
  input  logic       clear,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [4:0] disp_sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] remaining,
  output logic [7:0] stock_50,
  output logic [7:0] stock_20,
  output logic [7:0] stock_10,
  output logic [7:0] stock_5,
  output logic [7:0] stock_1
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t          state, state_nx;
  logic [TO_W-1:0] to_cnt;
  logic [4:0]      nonzero, avail, pick;
  logic            ack_take, timed_out, reload;

  assign ack_take  = (state == ST_REQ) && disp_ack;
  assign timed_out = (state == ST_REQ) && !disp_ack && (to_cnt == TO_LAST);
  assign reload    = (state == ST_IDLE) && restock;

  coin_stock_bank #(.STOCK_INIT(STOCK_INIT)) u_bank (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .reload   (reload),
    .dec      (ack_take),
    .dec_sel  (disp_sel),
    .stock_50 (stock_50),
    .stock_20 (stock_20),
    .stock_10 (stock_10),
    .stock_5  (stock_5),
    .stock_1  (stock_1),
    .nonzero  (nonzero)
  );

  // Candidates: in stock and not larger than what is still owed.
  assign avail = nonzero & {remaining >= DEN_50, remaining >= DEN_20,
                            remaining >= DEN_10, remaining >= DEN_5,
                            remaining >= DEN_1};

  always_comb begin
    pick     = '0;
    state_nx = state;
    if      (avail[4]) pick = SEL_50;
    else if (avail[3]) pick = SEL_20;
    else if (avail[2]) pick = SEL_10;
    else if (avail[1]) pick = SEL_5;
    else if (avail[0]) pick = SEL_1;

    case (state)
      ST_IDLE:   if (start) state_nx = (change_amount == '0) ? ST_DONE : ST_SELECT;
      ST_SELECT: begin
        if (remaining == '0)  state_nx = ST_DONE;
        else if (pick != '0)  state_nx = ST_REQ;
        else                  state_nx = ST_FAULT;
      end
      ST_REQ: begin
        if (disp_ack)       state_nx = ST_SELECT;
        else if (timed_out) state_nx = ST_FAULT;
      end
      ST_DONE:   state_nx = ST_IDLE;
      ST_FAULT:  if (clear) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      disp_sel   <= '0;
      fault_code <= FC_NONE;
      to_cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (start) remaining <= change_amount;
        ST_SELECT: begin
          disp_sel <= pick;
          to_cnt   <= '0;
          if ((remaining != '0) && (pick == '0)) fault_code <= FC_SHORTFALL;
        end
        ST_REQ: begin
          if (disp_ack)       remaining  <= remaining - sel_value(disp_sel);
          else if (timed_out) fault_code <= FC_TIMEOUT;
          else                to_cnt     <= to_cnt + TO_W'(1);
        end
        ST_FAULT: if (clear) fault_code <= FC_NONE;
        default: ;
      endcase
    end
  end

  assign disp_req = (state == ST_REQ);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: two dispensers (stock 20 and stock 2) behind one
// shared stimulus port, checked against a greedy change-making model.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int ACK_TO = 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst, start, restock, clear, disp_ack, sel_b;
  logic [7:0] change_amount;

  logic       a_req, b_req, a_busy, b_busy, a_done, b_done, a_fault, b_fault;
  logic [4:0] a_sel, b_sel;
  logic [1:0] a_fc, b_fc;
  logic [7:0] a_rem, b_rem;
  logic [7:0] a_stk [5];
  logic [7:0] b_stk [5];

  logic       disp_req, busy, done, fault;
  logic [4:0] disp_sel;
  logic [1:0] fault_code;
  logic [7:0] remaining;
  logic [7:0] stk [5];

  int n_checks = 0;
  int n_fail   = 0;
  int m_stk [2][5];
  int exp_q[$];
  int got_q[$];
  int exp_rem, exp_short;
  int got_done, got_fault, got_done_cyc, first_req_cyc, sel_unstable;

  always #5 sys_clk = ~sys_clk;

  change_dispenser #(.STOCK_INIT(8'd20), .ACK_TIMEOUT(ACK_TO), .TO_W(10)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start & ~sel_b),
    .change_amount(change_amount), .restock(restock & ~sel_b),
    .clear(clear & ~sel_b), .disp_ack(disp_ack & ~sel_b),
    .disp_req(a_req), .disp_sel(a_sel), .busy(a_busy), .done(a_done),
    .fault(a_fault), .fault_code(a_fc), .remaining(a_rem),
    .stock_50(a_stk[0]), .stock_20(a_stk[1]), .stock_10(a_stk[2]),
    .stock_5(a_stk[3]), .stock_1(a_stk[4]));

  change_dispenser #(.STOCK_INIT(8'd2), .ACK_TIMEOUT(ACK_TO), .TO_W(10)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start & sel_b),
    .change_amount(change_amount), .restock(restock & sel_b),
    .clear(clear & sel_b), .disp_ack(disp_ack & sel_b),
    .disp_req(b_req), .disp_sel(b_sel), .busy(b_busy), .done(b_done),
    .fault(b_fault), .fault_code(b_fc), .remaining(b_rem),
    .stock_50(b_stk[0]), .stock_20(b_stk[1]), .stock_10(b_stk[2]),
    .stock_5(b_stk[3]), .stock_1(b_stk[4]));

  always_comb begin
    disp_req   = sel_b ? b_req   : a_req;
    disp_sel   = sel_b ? b_sel   : a_sel;
    busy       = sel_b ? b_busy  : a_busy;
    done       = sel_b ? b_done  : a_done;
    fault      = sel_b ? b_fault : a_fault;
    fault_code = sel_b ? b_fc    : a_fc;
    remaining  = sel_b ? b_rem   : a_rem;
    for (int i = 0; i < 5; i++) stk[i] = sel_b ? b_stk[i] : a_stk[i];
  end

  function automatic int dval(input int i);
    case (i)
      0: return 50;
      1: return 20;
      2: return 10;
      3: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int sel_to_val(input logic [4:0] s);
    case (s)
      5'b10000: return 50;
      5'b01000: return 20;
      5'b00100: return 10;
      5'b00010: return 5;
      5'b00001: return 1;
      default:  return -1;
    endcase
  endfunction

  // Greedy change-making over the model stock of the selected dispenser.
  task automatic model_txn(input int amount);
    int rem = amount;
    int w = sel_b ? 1 : 0;
    exp_q.delete();
    exp_short = 0;
    while (rem > 0) begin
      int p = -1;
      for (int i = 0; i < 5; i++)
        if (p < 0 && dval(i) <= rem && m_stk[w][i] > 0) p = i;
      if (p < 0) begin
        exp_short = 1;
        break;
      end
      exp_q.push_back(dval(p));
      rem -= dval(p);
      m_stk[w][p]--;
    end
    exp_rem = rem;
  endtask

  task automatic set_model_stock(input int w, input int v);
    for (int i = 0; i < 5; i++) m_stk[w][i] = v;
  endtask

  // Called at a negedge; plays the mechanism with random ack delays.
  task automatic drive_txn(input int amount, input int max_delay, input bit with_restock);
    int cyc = 0;
    got_q.delete();
    got_done = 0; got_fault = 0; got_done_cyc = -1; first_req_cyc = -1; sel_unstable = 0;
    change_amount = 8'(amount);
    start   = 1'b1;
    restock = with_restock;
    @(negedge sys_clk);
    start   = 1'b0;
    restock = 1'b0;
    while (!got_done && !got_fault && cyc < 3000) begin
      if (done) begin
        got_done = 1;
        got_done_cyc = cyc;
      end else if (fault) begin
        got_fault = 1;
      end else if (disp_req) begin
        logic [4:0] s;
        int d;
        s = disp_sel;
        d = $urandom_range(0, max_delay);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        got_q.push_back(sel_to_val(s));
        for (int k = 0; k < d; k++) begin
          @(negedge sys_clk);
          cyc++;
          if (disp_sel !== s || disp_req !== 1'b1) sel_unstable++;
        end
        disp_ack = 1'b1;
        @(negedge sys_clk);
        disp_ack = 1'b0;
        cyc++;
      end
      if (!got_done && !got_fault) begin
        @(negedge sys_clk);
        cyc++;
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic do_restock;
    restock = 1'b1;
    @(negedge sys_clk);
    restock = 1'b0;
    set_model_stock(sel_b ? 1 : 0, sel_b ? 2 : 20);
  endtask

  task automatic test_reset;
    n_checks++; if (disp_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", disp_req); end
    n_checks++; if (disp_sel !== 5'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 00000", disp_sel); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy %b done %b fault %b want 000", busy, done, fault); end
    n_checks++; if (fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_fc: got %b want 00", fault_code); end
    n_checks++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", remaining); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (int'(stk[i]) != 20) begin n_fail++; $display("FAIL reset_stock%0d: got %0d want 20", dval(i), stk[i]); end
    end
  endtask

  task automatic test_greedy_87;
    int want_stk [5] = '{19, 19, 19, 19, 18};
    model_txn(87);
    drive_txn(87, 3, 1'b0);
    n_checks++; if (got_done !== 1) begin n_fail++; $display("FAIL g87_done: got %0d want 1", got_done); end
    n_checks++; if (first_req_cyc != 1) begin n_fail++; $display("FAIL g87_latency: req at cyc %0d want 1", first_req_cyc); end
    n_checks++; if (got_q.size() != 6 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL g87_len: got %0d want 6", got_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL g87_seq%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (sel_unstable != 0) begin n_fail++; $display("FAIL g87_sel_stable: got %0d changes want 0", sel_unstable); end
    n_checks++; if (remaining !== 8'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL g87_end: rem %0d done %b want 0 0", remaining, done); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (int'(stk[i]) != want_stk[i]) begin n_fail++; $display("FAIL g87_stock%0d: got %0d want %0d", dval(i), stk[i], want_stk[i]); end
    end
  endtask

  task automatic test_deplete_50;
    int bad = 0;
    set_model_stock(0, 20);
    for (int t = 0; t < 20; t++) begin
      model_txn(50);
      drive_txn(50, 2, t == 0);
      if (!got_done || got_q.size() != 1 || got_q[0] != 50) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL dep50_txns: got %0d bad want 0", bad); end
    n_checks++; if (stk[0] !== 8'd0) begin n_fail++; $display("FAIL dep50_stock50: got %0d want 0", stk[0]); end
    model_txn(60);
    drive_txn(60, 2, 1'b0);
    n_checks++; if (got_done !== 1 || got_q.size() != 3) begin
      n_fail++; $display("FAIL dep60_len: done %0d len %0d want 1 3", got_done, got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] != 20) begin n_fail++; $display("FAIL dep60_seq%0d: got %0d want 20", i, got_q[i]); end
    end
    n_checks++; if (stk[1] !== 8'd17) begin n_fail++; $display("FAIL dep60_stock20: got %0d want 17", stk[1]); end
  endtask

  task automatic test_zero_and_ignored;
    model_txn(0);
    drive_txn(0, 0, 1'b0);
    n_checks++; if (got_done !== 1 || got_done_cyc != 0) begin
      n_fail++; $display("FAIL zero_done: done %0d at cyc %0d want 1 at 0", got_done, got_done_cyc); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL zero_noreq: got %0d reqs want 0", got_q.size()); end
    n_checks++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL zero_rem: got %0d want 0", remaining); end
    disp_ack = 1'b1; clear = 1'b1;
    @(negedge sys_clk);
    disp_ack = 1'b0; clear = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0 || disp_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: busy %b req %b want 0 0", busy, disp_req); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (int'(stk[i]) != m_stk[0][i]) begin n_fail++; $display("FAIL idle_stock%0d: got %0d want %0d", dval(i), stk[i], m_stk[0][i]); end
    end
  endtask

  task automatic test_timeout;
    int cnt = 0;
    do_restock;
    change_amount = 8'd10;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int k = 0; k < 8 && !disp_req; k++) @(negedge sys_clk);
    n_checks++; if (disp_req !== 1'b1 || disp_sel !== 5'b00100) begin
      n_fail++; $display("FAIL to_req: req %b sel %b want 1 00100", disp_req, disp_sel); end
    while (!fault && cnt < 2 * ACK_TO) begin
      @(negedge sys_clk);
      cnt++;
    end
    n_checks++; if (cnt != ACK_TO) begin n_fail++; $display("FAIL to_cycles: got %0d want %0d", cnt, ACK_TO); end
    n_checks++; if (fault_code !== 2'b10 || disp_req !== 1'b0) begin
      n_fail++; $display("FAIL to_code: fc %b req %b want 10 0", fault_code, disp_req); end
    n_checks++; if (remaining !== 8'd10) begin n_fail++; $display("FAIL to_rem: got %0d want 10", remaining); end
    n_checks++; if (stk[2] !== 8'd20) begin n_fail++; $display("FAIL to_stock10: got %0d want 20", stk[2]); end
    clear = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00 || remaining !== 8'd10) begin
      n_fail++; $display("FAIL to_clear: busy %b fault %b fc %b rem %0d want 0 0 00 10", busy, fault, fault_code, remaining); end
  endtask

  task automatic test_shortfall;
    sel_b = 1'b1;
    @(negedge sys_clk);
    model_txn(8);
    drive_txn(8, 2, 1'b0);
    n_checks++; if (got_fault !== 1 || fault_code !== 2'b01) begin
      n_fail++; $display("FAIL sf_fault: fault %0d fc %b want 1 01", got_fault, fault_code); end
    n_checks++; if (int'(remaining) != exp_rem || exp_rem != 1) begin
      n_fail++; $display("FAIL sf_rem: got %0d want 1", remaining); end
    n_checks++; if (got_q.size() != 3 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sf_len: got %0d want 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL sf_seq%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    clear = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0 || fault_code !== 2'b00 || remaining !== 8'd1) begin
      n_fail++; $display("FAIL sf_clear: busy %b fc %b rem %0d want 0 00 1", busy, fault_code, remaining); end
    sel_b = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int amt = $urandom_range(1, 255);
      model_txn(amt);
      drive_txn(amt, 3, 1'b0);
      n_checks++; if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd%0d_len: amt %0d got %0d want %0d", t, amt, got_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_seq%0d: got %0d want %0d", t, i, got_q[i], exp_q[i]); end
      end
      if (exp_short != 0) begin
        n_checks++; if (got_fault !== 1 || fault_code !== 2'b01 || int'(remaining) != exp_rem) begin
          n_fail++; $display("FAIL rnd%0d_short: fault %0d fc %b rem %0d want 1 01 %0d", t, got_fault, fault_code, remaining, exp_rem); end
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0;
      end else begin
        n_checks++; if (got_done !== 1 || remaining !== 8'd0 || done !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_done: done %0d rem %0d pulse %b want 1 0 0", t, got_done, remaining, done); end
      end
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (int'(stk[i]) != m_stk[0][i]) begin n_fail++; $display("FAIL rnd%0d_stock%0d: got %0d want %0d", t, dval(i), stk[i], m_stk[0][i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_restock;
    change_amount = 8'd87;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int k = 0; k < 8 && !disp_req; k++) @(negedge sys_clk);
    disp_ack = 1'b1;
    @(negedge sys_clk);
    disp_ack = 1'b0;
    @(negedge sys_clk);
    change_amount = 8'd5;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n_checks++; if (disp_req !== 1'b1 || disp_sel !== 5'b01000 || remaining !== 8'd37) begin
      n_fail++; $display("FAIL rm_start_ignored: req %b sel %b rem %0d want 1 01000 37", disp_req, disp_sel, remaining); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_checks++; if (disp_req !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0) begin
      n_fail++; $display("FAIL rm_drop: req %b busy %b rem %0d want 0 0 0", disp_req, busy, remaining); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (stk[i] !== 8'd20) begin n_fail++; $display("FAIL rm_stock%0d: got %0d want 20", dval(i), stk[i]); end
    end
    sys_rst = 1'b0;
    set_model_stock(0, 20);
    set_model_stock(1, 2);
    @(negedge sys_clk);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; restock = 1'b0; clear = 1'b0;
    disp_ack = 1'b0; sel_b = 1'b0; change_amount = '0;
    set_model_stock(0, 20);
    set_model_stock(1, 2);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    test_reset;
    test_greedy_87;
    test_deplete_50;
    test_zero_and_ignored;
    test_timeout;
    test_shortfall;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
